// File: rtl/pipe_id_hazard_sb.sv
// Purpose : ID-stage hazard/forwarding controller with a shift scoreboard of in-flight destinations.
// Latency : fwd_sel/wpcir combinational in the ID cycle; scoreboard, ebubble_o, mdu_busy, stall_cnt registered.
// Backpr. : wpcir=0 holds PC and IF/ID and injects a bubble into EXE; id_bubble overrides any stall.
// Ports   : clock/resetn (sync, active-low); id_* describe the instruction in ID;
//           fwd_sel[p*SELW +: SELW] = 0 regfile or k = scoreboard stage k; wpcir = 0 stalls;
//           ebubble_o = stage-1 holds a bubble; mdu_busy = MUL/DIV occupied; stall_cnt = saturating stall count.
module pipe_id_hazard_sb #(
    parameter  int NRD      = 2,
    parameter  int RW       = 5,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_LAT = 1,
    parameter  int MDU_LAT  = 3,
    localparam int SELW     = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  id_bubble,
    input  logic [NRD*RW-1:0]     id_rs,
    input  logic [NRD-1:0]        id_rs_use,
    input  logic                  id_wreg,
    input  logic [RW-1:0]         id_rn,
    input  logic [1:0]            id_kind,
    output logic [NRD*SELW-1:0]   fwd_sel,
    output logic                  wpcir,
    output logic                  ebubble_o,
    output logic                  mdu_busy,
    output logic [15:0]           stall_cnt
);
    localparam int          MCW      = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [1:0]  K_LOAD   = 2'b01;
    localparam logic [1:0]  K_MDU    = 2'b10;

    // Scoreboard stage k holds the destination of the instruction k stages past ID;
    // r_rdy is the first stage index at which that result can be forwarded.
    logic [DEPTH:1]     r_v;
    logic [RW-1:0]      r_rn  [1:DEPTH];
    logic [SELW-1:0]    r_rdy [1:DEPTH];
    logic [MCW-1:0]     r_mdu_cnt;
    logic [15:0]        r_stall_cnt;
    logic               r_ebubble;

    logic [SELW-1:0]    w_port_sel [NRD];
    logic [NRD-1:0]     w_port_haz;
    logic               w_struct_haz;
    logic               w_wpcir;
    logic               w_issue;
    logic [SELW-1:0]    w_rdy_in;

    // Per port: scan oldest to youngest so the youngest matching stage has the last word.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            w_port_sel[p] = '0;
            w_port_haz[p] = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (id_rs_use[p] && r_v[k] && (r_rn[k] == id_rs[p*RW +: RW])
                    && (id_rs[p*RW +: RW] != '0)) begin
                    if (SELW'(k) >= r_rdy[k]) begin
                        w_port_sel[p] = SELW'(k);
                        w_port_haz[p] = 1'b0;
                    end else begin
                        w_port_sel[p] = '0;
                        w_port_haz[p] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_struct_haz = (id_kind == K_MDU) && (r_mdu_cnt != '0);
    // A squashed instruction never stalls: the bubble wins over any hazard.
    assign w_wpcir      = ~(~id_bubble & ((|w_port_haz) | w_struct_haz));
    assign w_issue      = w_wpcir & ~id_bubble;

    always_comb begin
        w_rdy_in = SELW'(1);
        if (id_kind == K_LOAD) begin
            w_rdy_in = SELW'(1 + LOAD_LAT);
        end else if (id_kind == K_MDU) begin
            w_rdy_in = SELW'(MDU_LAT);
        end
    end

    always_comb begin
        fwd_sel = '0;
        for (int p = 0; p < NRD; p++) begin
            fwd_sel[p*SELW +: SELW] = id_bubble ? '0 : w_port_sel[p];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_v         <= '0;
            r_mdu_cnt   <= '0;
            r_stall_cnt <= '0;
            r_ebubble   <= 1'b1;
            for (int k = 1; k <= DEPTH; k++) begin
                r_rn[k]  <= '0;
                r_rdy[k] <= '0;
            end
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_v[k]   <= r_v[k-1];
                r_rn[k]  <= r_rn[k-1];
                r_rdy[k] <= r_rdy[k-1];
            end
            // Writes to r0 never become entries, so r0 can never forward or stall.
            r_v[1]   <= w_issue & id_wreg & (id_rn != '0);
            r_rn[1]  <= id_rn;
            r_rdy[1] <= w_rdy_in;

            if (w_issue && (id_kind == K_MDU)) begin
                r_mdu_cnt <= MCW'(MDU_LAT - 1);
            end else if (r_mdu_cnt != '0) begin
                r_mdu_cnt <= r_mdu_cnt - MCW'(1);
            end

            r_ebubble <= ~w_wpcir | id_bubble;

            if (!w_wpcir && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign wpcir     = w_wpcir;
    assign ebubble_o = r_ebubble;
    assign mdu_busy  = (r_mdu_cnt != '0);
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_id_hazard_sb.sv
// Purpose : directed, table-driven check of pipe_id_hazard_sb (DEPTH=3, LOAD_LAT=1, MDU_LAT=3).
// Latency : one table row per clock; inputs driven on negedge, outputs sampled 1ns later.
// Backpr. : stalls are exercised by holding the ID inputs steady across rows.
module tb_pipe_id_hazard_sb;
    logic        clock;
    logic        resetn;
    logic        id_bubble;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_use;
    logic        id_wreg;
    logic [4:0]  id_rn;
    logic [1:0]  id_kind;
    logic [3:0]  fwd_sel;
    logic        wpcir;
    logic        ebubble_o;
    logic        mdu_busy;
    logic [15:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    pipe_id_hazard_sb #(.NRD(2), .RW(5), .DEPTH(3), .LOAD_LAT(1), .MDU_LAT(3)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .id_bubble (id_bubble),
        .id_rs     (id_rs),
        .id_rs_use (id_rs_use),
        .id_wreg   (id_wreg),
        .id_rn     (id_rn),
        .id_kind   (id_kind),
        .fwd_sel   (fwd_sel),
        .wpcir     (wpcir),
        .ebubble_o (ebubble_o),
        .mdu_busy  (mdu_busy),
        .stall_cnt (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int rst, bub, ru, rs0, rs1, wreg, rn, kind;
        int f0, f1, wp, eb, mb, sc, chk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rst, int bub, int ru, int rs0, int rs1, int wreg, int rn,
                                int kind, int f0, int f1, int wp, int eb, int mb, int sc, int chk);
        vec_t v;
        v.rst = rst; v.bub = bub; v.ru = ru; v.rs0 = rs0; v.rs1 = rs1;
        v.wreg = wreg; v.rn = rn; v.kind = kind;
        v.f0 = f0; v.f1 = f1; v.wp = wp; v.eb = eb; v.mb = mb; v.sc = sc; v.chk = chk;
        return v;
    endfunction

    task automatic check(input string name, input int row, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic drive(input int rst, input int bub, input int ru, input int rs0, input int rs1,
                         input int wreg, input int rn, input int kind);
        @(negedge clock);
        resetn    = rst[0];
        id_bubble = bub[0];
        id_rs_use = ru[1:0];
        id_rs     = {rs1[4:0], rs0[4:0]};
        id_wreg   = wreg[0];
        id_rn     = rn[4:0];
        id_kind   = kind[1:0];
        #1;
    endtask

    initial begin
        resetn = 1'b0; id_bubble = 1'b0; id_rs = '0; id_rs_use = '0;
        id_wreg = 1'b0; id_rn = '0; id_kind = '0;

        //          rst bub ru rs0 rs1 wr rn kd | f0 f1 wp eb mb sc chk
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0)); // 0 reset
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1)); // 1 reset state
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0,  0, 0, 1, 1, 0, 0, 1)); // 2 add r3
        tbl.push_back(mk(1, 0, 1, 3, 0, 1, 4, 0,  1, 0, 1, 0, 0, 0, 1)); // 3 read r3 -> stage1
        tbl.push_back(mk(1, 0, 2, 0, 3, 0, 0, 0,  0, 2, 1, 0, 0, 0, 1)); // 4 read r3 -> stage2
        tbl.push_back(mk(1, 0, 3, 3, 4, 0, 0, 0,  3, 2, 1, 0, 0, 0, 1)); // 5 r3 s3, r4 s2
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1,  0, 0, 1, 0, 0, 0, 1)); // 6 lw r3
        tbl.push_back(mk(1, 0, 1, 3, 0, 1, 6, 0,  0, 0, 0, 0, 0, 0, 1)); // 7 load-use stall
        tbl.push_back(mk(1, 0, 1, 3, 0, 1, 6, 0,  2, 0, 1, 1, 0, 1, 1)); // 8 fwd from MEM
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0,  0, 0, 1, 0, 0, 1, 1)); // 9 add r7
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0,  0, 0, 1, 0, 0, 1, 1)); // 10 add r7 again
        tbl.push_back(mk(1, 0, 3, 6, 7, 0, 0, 0,  3, 1, 1, 0, 0, 1, 1)); // 11 youngest wins
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 2,  0, 0, 1, 0, 0, 1, 1)); // 12 mul r5
        tbl.push_back(mk(1, 0, 1, 5, 0, 1, 8, 2,  0, 0, 0, 0, 1, 1, 1)); // 13 div reads r5
        tbl.push_back(mk(1, 0, 1, 5, 0, 1, 8, 2,  0, 0, 0, 1, 1, 2, 1)); // 14 still stalled
        tbl.push_back(mk(1, 0, 1, 5, 0, 1, 8, 2,  3, 0, 1, 1, 0, 3, 1)); // 15 issues, fwd 3
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 3, 1)); // 16 mdu busy
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 3, 1)); // 17 mdu busy
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1,  0, 0, 1, 0, 0, 3, 1)); // 18 lw r3
        tbl.push_back(mk(1, 1, 1, 3, 0, 1, 9, 0,  0, 0, 1, 0, 0, 3, 1)); // 19 squashed use
        tbl.push_back(mk(1, 0, 3, 9, 3, 0, 0, 0,  0, 2, 1, 1, 0, 3, 1)); // 20 no r9 entry
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1,  0, 0, 1, 0, 0, 3, 1)); // 21 lw r0
        tbl.push_back(mk(1, 0, 3, 0, 0, 1, 0, 2,  0, 0, 1, 0, 0, 3, 1)); // 22 read r0, mul r0
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1,  0, 0, 1, 0, 1, 3, 1)); // 23 lw r3
        tbl.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 1, 3, 1)); // 24 reset mid-stall
        tbl.push_back(mk(1, 0, 1, 3, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1)); // 25 after reset
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 10, 3, 0, 0, 1, 0, 0, 0, 1)); // 26 kind 11 as ALU
        tbl.push_back(mk(1, 0, 2, 10, 10, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1)); // 27 only port1 used

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].bub, tbl[i].ru, tbl[i].rs0, tbl[i].rs1,
                  tbl[i].wreg, tbl[i].rn, tbl[i].kind);
            if (tbl[i].chk != 0) begin
                check("fwd_sel0", i, int'(fwd_sel[1:0]), tbl[i].f0);
                check("fwd_sel1", i, int'(fwd_sel[3:2]), tbl[i].f1);
                check("wpcir",    i, int'(wpcir),        tbl[i].wp);
                check("ebubble",  i, int'(ebubble_o),    tbl[i].eb);
                check("mdu_busy", i, int'(mdu_busy),     tbl[i].mb);
                check("stall_cnt", i, int'(stall_cnt),   tbl[i].sc);
            end
        end

        // Pure structural interlock: mul then back-to-back div without register reads.
        drive(1, 0, 0, 0, 0, 1, 11, 2);
        check("seq_mul_wpcir", 100, int'(wpcir), 1);
        check("seq_mul_busy",  100, int'(mdu_busy), 0);
        drive(1, 0, 0, 0, 0, 1, 12, 2);
        check("seq_div1_wpcir", 101, int'(wpcir), 0);
        check("seq_div1_busy",  101, int'(mdu_busy), 1);
        drive(1, 0, 0, 0, 0, 1, 12, 2);
        check("seq_div2_wpcir", 102, int'(wpcir), 0);
        check("seq_div2_ebub",  102, int'(ebubble_o), 1);
        drive(1, 0, 0, 0, 0, 1, 12, 2);
        check("seq_div3_wpcir", 103, int'(wpcir), 1);
        check("seq_div3_busy",  103, int'(mdu_busy), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("seq_idle_busy",  104, int'(mdu_busy), 1);
        check("seq_idle_ebub",  104, int'(ebubble_o), 0);
        check("seq_idle_cnt",   104, int'(stall_cnt), 2);
        // Squashed MUL/DIV while busy: no stall and no reload of the unit.
        drive(1, 1, 0, 0, 0, 1, 13, 2);
        check("seq_sq_wpcir",   105, int'(wpcir), 1);
        check("seq_sq_busy",    105, int'(mdu_busy), 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("seq_sq_noissue", 106, int'(mdu_busy), 0);
        check("seq_sq_ebub",    106, int'(ebubble_o), 1);
        check("seq_sq_cnt",     106, int'(stall_cnt), 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
